// File: rtl/jk_ctrl_pkg.sv
// Shared JK command codes and scheduler FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package jk_ctrl_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } jk_state_e;

endpackage

// File: rtl/jk_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module jk_rr_arb
   import jk_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] win_oh,
   output logic [IDW-1:0]  win_id,
   output logic            win_vld
);

   // Scan NREQ slots starting at the pointer; the first active request wins.
   always_comb begin
      int j;
      win_oh  = '0;
      win_id  = '0;
      win_vld = 1'b0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) begin
            j = j - NREQ;
         end
         if (!win_vld && req[j]) begin
            win_vld   = 1'b1;
            win_oh[j] = 1'b1;
            win_id    = j[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler sharing a JK flop bank: grant one command, drive its jk pair one clock, return q.
// Latency: req sampled at t, gnt/jk_bus in t+1, rsp_valid in t+2; one command per 3 cycles.
// Backpressure: requesters hold req/idx/cmd until gnt; requests seen in ISSUE/RESP are ignored.
// Optional JK_LOCK_EN adds req_lock: a locked winner keeps the pointer and owns the next arbitration.
module jk_bank_sched
   import jk_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int NFF  = 8,
   parameter int IDXW = 3,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*IDXW-1:0] req_idx,
   input  logic [NREQ*2-1:0]    req_cmd,
`ifdef JK_LOCK_EN
   input  logic [NREQ-1:0]      req_lock,
`endif
   output logic [NREQ-1:0]      gnt,
   output logic [2*NFF-1:0]     jk_bus,
   input  logic [NFF-1:0]       bank_q,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_q,
   output logic                 rsp_err
);

   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   jk_state_e            state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       id_q, id_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic                 err_q, err_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [2*NFF-1:0]     jk_bus_q, jk_bus_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]       rsp_id_q, rsp_id_d;
   logic                 rsp_err_q, rsp_err_d;
`ifdef JK_LOCK_EN
   logic                 lock_q, lock_d;
   logic                 sel_lock;
`endif

   logic [NREQ-1:0]      win_oh;
   logic [IDW-1:0]       win_id;
   logic                 win_vld;
   logic [IDXW-1:0]      sel_idx;
   logic [1:0]           sel_cmd;
   logic [IDW-1:0]       ptr_nxt;

   jk_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .win_oh  (win_oh),
      .win_id  (win_id),
      .win_vld (win_vld)
   );

   // Select the winning requester's index/command (and lock) slices.
   always_comb begin
      sel_idx = '0;
      sel_cmd = JK_HOLD;
`ifdef JK_LOCK_EN
      sel_lock = 1'b0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         if (win_id == i[IDW-1:0]) begin
            sel_idx = req_idx[i*IDXW +: IDXW];
            sel_cmd = req_cmd[2*i +: 2];
`ifdef JK_LOCK_EN
            sel_lock = req_lock[i];
`endif
         end
      end
   end

   assign ptr_nxt = (id_q == LAST_ID) ? '0 : id_q + 1'b1;

   // FSM next state and next values of all registered outputs.
   // The latched command lives directly in jk_bus_q, which is built in IDLE.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      idx_d       = idx_q;
      err_d       = err_q;
      gnt_d       = '0;
      jk_bus_d    = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = 1'b0;
`ifdef JK_LOCK_EN
      lock_d      = lock_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = ISSUE;
               id_d    = win_id;
               idx_d   = sel_idx;
               gnt_d   = win_oh;
`ifdef JK_LOCK_EN
               lock_d  = sel_lock;
`endif
               // An index matching no flop leaves the bus at hold and flags an error.
               err_d   = 1'b1;
               for (int f = 0; f < NFF; f++) begin
                  if (sel_idx == f[IDXW-1:0]) begin
                     err_d               = 1'b0;
                     jk_bus_d[2*f +: 2] = sel_cmd;
                  end
               end
            end
         end
         ISSUE: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_err_d   = err_q;
`ifdef JK_LOCK_EN
            // Parking the pointer on a locked winner lets it win again if still requesting.
            ptr_d       = lock_q ? id_q : ptr_nxt;
`else
            ptr_d       = ptr_nxt;
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset forces the bank bus to hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         gnt_q       <= '0;
         jk_bus_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
`ifdef JK_LOCK_EN
         lock_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         gnt_q       <= gnt_d;
         jk_bus_q    <= jk_bus_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
`ifdef JK_LOCK_EN
         lock_q      <= lock_d;
`endif
      end
   end

   // Response q: the bank has already updated, so mux the targeted flop directly.
   always_comb begin
      rsp_q = 1'b0;
      if (rsp_valid_q && !rsp_err_q) begin
         for (int f = 0; f < NFF; f++) begin
            if (idx_q == f[IDXW-1:0]) begin
               rsp_q = bank_q[f];
            end
         end
      end
   end

   assign gnt       = gnt_q;
   assign jk_bus    = jk_bus_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: directed commands, scoreboard queues, negedge monitor, behavioural JK bank.
// Latency: n/a.
// Backpressure: n/a.
module tb_jk_bank_sched;

   localparam int NREQ = 4;
   localparam int NFF  = 6;
   localparam int IDXW = 3;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*IDXW-1:0] req_idx = '0;
   logic [NREQ*2-1:0]    req_cmd = '0;
`ifdef JK_LOCK_EN
   logic [NREQ-1:0]      req_lock = '0;
`endif
   logic [NREQ-1:0]      gnt;
   logic [2*NFF-1:0]     jk_bus;
   logic [NFF-1:0]       bank = '0;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic                 rsp_q;
   logic                 rsp_err;

   typedef struct packed {
      logic [NREQ-1:0]  g;
      logic [2*NFF-1:0] jk;
   } gexp_t;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           q;
      logic           err;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_gnt = -100;
   int rr_last = -1;
   bit rr_phase = 1'b0;

   jk_bank_sched #(
      .NREQ (NREQ),
      .NFF  (NFF),
      .IDXW (IDXW),
      .IDW  (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_idx   (req_idx),
      .req_cmd   (req_cmd),
`ifdef JK_LOCK_EN
      .req_lock  (req_lock),
`endif
      .gnt       (gnt),
      .jk_bus    (jk_bus),
      .bank_q    (bank),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_q     (rsp_q),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // Behavioural JK bank, not reset by the scheduler.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int f = 0; f < NFF; f++) begin
         case (jk_bus[2*f +: 2])
            2'b01:   bank[f] <= 1'b0;
            2'b10:   bank[f] <= 1'b1;
            2'b11:   bank[f] <= ~bank[f];
            default: bank[f] <= bank[f];
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT grants or responds.
   always @(negedge clk) begin
      gexp_t ge;
      rexp_t re;
      if (rst) begin
         if (!rr_phase) rr_last = -1;
         if (gnt != '0) begin
            if (gq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL gnt_unexpected got=%b", gnt);
            end else begin
               ge = gq.pop_front();
               chk("gnt", 32'(gnt), 32'(ge.g));
               chk("jk_issue", 32'(jk_bus), 32'(ge.jk));
            end
            if (rr_phase) begin
               if (rr_last >= 0) chk("rr_spacing", 32'(cyc - rr_last), 32'd3);
               rr_last = cyc;
            end
            last_gnt = cyc;
         end else begin
            chk("jk_idle", 32'(jk_bus), 32'd0);
         end
         if (rsp_valid) begin
            if (rq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rsp_unexpected id=%0d", rsp_id);
            end else begin
               re = rq.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(re.id));
               chk("rsp_q", 32'(rsp_q), 32'(re.q));
               chk("rsp_err", 32'(rsp_err), 32'(re.err));
               chk("rsp_lat", 32'(cyc - last_gnt), 32'd1);
            end
         end
      end
   end

   task automatic wait_gnt(input int r, output int n);
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (gnt[r]) break;
      end
      if (!gnt[r]) begin
         total++;
         bad++;
         $display("FAIL gnt_timeout req=%0d got=%b want=1", r, gnt[r]);
      end
   endtask

   task automatic post(input int r, input logic [IDXW-1:0] idx, input logic [1:0] cmd);
      req[r] = 1'b1;
      req_idx[r*IDXW +: IDXW] = idx;
      req_cmd[r*2 +: 2] = cmd;
   endtask

   task automatic expect_op(input int r, input logic [2*NFF-1:0] ejk, input logic eq, input logic eerr);
      gexp_t ge;
      rexp_t re;
      ge.g = '0;
      ge.g[r] = 1'b1;
      ge.jk = ejk;
      re.id = IDW'(r);
      re.q = eq;
      re.err = eerr;
      gq.push_back(ge);
      rq.push_back(re);
   endtask

   task automatic op(input int r, input logic [IDXW-1:0] idx, input logic [1:0] cmd,
                     input logic [2*NFF-1:0] ejk, input logic eq, input logic eerr, output int n);
      expect_op(r, ejk, eq, eerr);
      post(r, idx, cmd);
      wait_gnt(r, n);
      req[r] = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      gexp_t ge;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_jk", 32'(jk_bus), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single op: requester 1 sets flop 3 (q was 0).
      op(1, 3'd3, 2'b10, 12'h080, 1'b1, 1'b0, n);
      chk("single_gnt_lat", 32'(n), 32'd1);
      settle();

      // Reset during ISSUE: grant is visible, then everything clears at once.
      ge.g = 4'b0100;
      ge.jk = 12'h200;
      gq.push_back(ge);
      post(2, 3'd4, 2'b10);
      wait_gnt(2, n);
      @(negedge clk);
      #1;
      rst = 1'b0;
      req = '0;
      #1;
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_jk", 32'(jk_bus), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_bank_hold", 32'(bank[4]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Round robin from pointer 0: each requester toggles its own flop.
      expect_op(0, 12'h003, 1'b1, 1'b0);
      expect_op(1, 12'h00C, 1'b1, 1'b0);
      expect_op(2, 12'h030, 1'b1, 1'b0);
      expect_op(3, 12'h0C0, 1'b0, 1'b0);
      expect_op(0, 12'h003, 1'b0, 1'b0);
      rr_phase = 1'b1;
      for (int r = 0; r < NREQ; r++) post(r, IDXW'(r), 2'b11);
      wait_gnt(0, n);
      wait_gnt(1, n);
      wait_gnt(2, n);
      wait_gnt(3, n);
      wait_gnt(0, n);
      req = '0;
      settle();
      rr_phase = 1'b0;

      // Two back-to-back toggles of flop 5.
      op(0, 3'd5, 2'b11, 12'hC00, 1'b1, 1'b0, n);
      op(0, 3'd5, 2'b11, 12'hC00, 1'b0, 1'b0, n);
      settle();

      // Out-of-range index: bus stays at hold, error reported.
      op(2, 3'd7, 2'b10, 12'h000, 1'b0, 1'b1, n);
      settle();

      // Hold commands report current q.
      op(3, 3'd3, 2'b00, 12'h000, 1'b0, 1'b0, n);
      op(1, 3'd1, 2'b00, 12'h000, 1'b1, 1'b0, n);
      settle();

`ifdef JK_LOCK_EN
      // Requester 0 keeps ownership for two locked grants, then releases.
      expect_op(0, 12'h000, 1'b0, 1'b0);
      expect_op(0, 12'h000, 1'b0, 1'b0);
      expect_op(0, 12'h000, 1'b0, 1'b0);
      expect_op(1, 12'h000, 1'b1, 1'b0);
      req_lock[0] = 1'b1;
      post(0, 3'd0, 2'b00);
      post(1, 3'd1, 2'b00);
      wait_gnt(0, n);
      wait_gnt(0, n);
      req_lock[0] = 1'b0;
      wait_gnt(0, n);
      req[0] = 1'b0;
      wait_gnt(1, n);
      req[1] = 1'b0;
      settle();
`endif

      repeat (4) @(posedge clk);
      #1;
      chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
      chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
